mem_ram: RTL and testbench

Parametrised single-port word RAM serving the multicycle RV32I core's unified instruction/data bus, replacing the fixed 256-word zero-wait memory. Depth, read latency and write latency are parameters; a busy handshake (`mem_rbusy`/`mem_wbusy`) lets the core stall for slower memories. Byte-lane writes and the read-strobe protocol are preserved, so `READ_LATENCY=1`, `WRITE_LATENCY=0` is cycle-identical to the current memory.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_busy_timer.sv | 59 +++++
 rtl/mem_ram.sv | 180 ++++++++++++++++++
 tb/tb_mem_ram.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the RV32I unified instruction/data memory.
//   WORD_W       : data word width (bits)
//   LANES        : byte lanes per word
//   MEM_ERR_WORD : word returned by an out-of-range read (when enabled)
//   mem_req_t    : one bus request (address, read strobe, write data/mask).
//                  Kept here so an IO-page decoder can reuse the same bundle.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  localparam logic [WORD_W-1:0] MEM_ERR_WORD = 32'hDEADBEEF;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic              rstrb;
    logic [WORD_W-1:0] wdata;
    logic [LANES-1:0]  wmask;
  } mem_req_t;

  // Any enabled byte lane turns the request into a write.
  function automatic logic req_is_write(input mem_req_t req);
    return |req.wmask;
  endfunction

endpackage : mem_pkg

// File: rtl/mem_busy_timer.sv
// -----------------------------------------------------------------------------
// mem_busy_timer
// Loadable down-counter producing a busy flag for the memory's read and write
// paths. Loading sets the count to LOAD_VAL; busy stays high while the count
// is non-zero. o_last marks the final busy cycle, i.e. the edge at the end of
// it takes the counter back to zero.
// With LOAD_VAL == 0 the timer never becomes busy and both outputs are
// constant 0.
//
// Ports:
//   clk     in  : clock, rising edge
//   resetn  in  : synchronous active-low reset
//   i_load  in  : load LOAD_VAL (only asserted while idle)
//   o_busy  out : count non-zero
//   o_last  out : count equals 1
// -----------------------------------------------------------------------------
module mem_busy_timer #(
  parameter int unsigned LOAD_VAL = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_load,
  output logic o_busy,
  output logic o_last
);

  if (LOAD_VAL == 0) begin : g_none

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, resetn, i_load};

    assign o_busy = 1'b0;
    assign o_last = 1'b0;

  end else begin : g_count

    localparam int unsigned CW = $clog2(LOAD_VAL + 1);

    logic [CW-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        r_cnt <= '0;
      end else if (i_load) begin
        r_cnt <= CW'(LOAD_VAL);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end

    assign o_busy = (r_cnt != '0);
    assign o_last = (r_cnt == CW'(1));

  end

endmodule : mem_busy_timer

// File: rtl/mem_ram.sv
// -----------------------------------------------------------------------------
// mem_ram
// Single-port 32-bit word RAM on the RV32I core's unified bus, with
// configurable read/write latency and a busy handshake so the core can stall.
// READ_LATENCY=1, WRITE_LATENCY=0 behaves exactly like a zero-wait memory
// with registered read data.
//
// Parameters:
//   DEPTH_WORDS   : words in the array, power of two, 16..65536
//   READ_LATENCY  : accepted strobe to valid mem_rdata, 1..4 cycles
//   WRITE_LATENCY : cycles mem_wbusy stays high after a write, 0..3
//   INIT_FILE     : initial image name, reserved
//
// Ports:
//   clk        in  : clock, rising edge
//   resetn     in  : synchronous active-low reset
//   mem_addr   in  : byte address, bits [1:0] ignored
//   mem_rstrb  in  : read request pulse
//   mem_wdata  in  : lane-aligned write data
//   mem_wmask  in  : byte write enables, non-zero = write request
//   mem_rdata  out : read data, held until the next completed read
//   mem_rbusy  out : read in flight
//   mem_wbusy  out : write in flight
//   mem_err    out : sticky out-of-range flag
//
// Build option:
//   MEM_ERR_EN : when defined, address bits above the array are checked;
//                out-of-range writes are dropped, reads return MEM_ERR_WORD
//                and mem_err latches. When undefined the address wraps and
//                mem_err is tied low.
// -----------------------------------------------------------------------------
module mem_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 256,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 0,
  parameter string       INIT_FILE     = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic        mem_rstrb,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic        mem_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  mem_req_t          w_req;
  logic [AW-1:0]     w_idx;
  logic              w_oor;
  logic              w_idle;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_wr_en;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_rd_last;
  logic              w_wr_last;

  assign w_req = '{addr: mem_addr, rstrb: mem_rstrb, wdata: mem_wdata, wmask: mem_wmask};
  assign w_idx = w_req.addr[AW+1:2];

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    w_oor = 1'b0;
`ifdef MEM_ERR_EN
    w_oor = |w_req.addr[31:AW+2];
`endif
  end

  // Requests are only taken when neither path is busy; a request coincident
  // with reset is dropped by folding resetn into the accept terms.
  assign w_idle   = !mem_rbusy && !mem_wbusy;
  assign w_rd_acc = resetn && w_req.rstrb && w_idle;
  assign w_wr_acc = resetn && req_is_write(w_req) && w_idle;
  assign w_wr_en  = w_wr_acc && !w_oor;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  // NOTE: the array has no reset branch; contents survive reset and the
  // block stays mappable onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_wr_en && w_req.wmask[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_req.wdata[8*i +: 8];
      end
    end
  end

  // Read of the pre-edge contents gives read-before-write for a same-cycle
  // read and write to the same word.
  assign w_rd_word = w_oor ? MEM_ERR_WORD : r_mem[w_idx];

  // ---------------------------------------------------------------------------
  // Busy timers: read busy covers the L-1 cycles before data is presented,
  // write busy covers WRITE_LATENCY cycles after the commit edge.
  // ---------------------------------------------------------------------------
  mem_busy_timer #(
    .LOAD_VAL (READ_LATENCY - 1)
  ) u_rd_timer (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_rd_acc),
    .o_busy (mem_rbusy),
    .o_last (w_rd_last)
  );

  mem_busy_timer #(
    .LOAD_VAL (WRITE_LATENCY)
  ) u_wr_timer (
    .clk    (clk),
    .resetn (resetn),
    .i_load (w_wr_acc),
    .o_busy (mem_wbusy),
    .o_last (w_wr_last)
  );

  // ---------------------------------------------------------------------------
  // Read data: the word is captured at acceptance and presented either
  // immediately (L=1) or on the edge that ends read busy.
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] r_held;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata <= '0;
      r_held  <= '0;
    end else begin
      if (w_rd_acc) begin
        r_held <= w_rd_word;
        if (READ_LATENCY == 1) begin
          r_rdata <= w_rd_word;
        end
      end else if (w_rd_last) begin
        r_rdata <= r_held;
      end
    end
  end

  assign mem_rdata = r_rdata;

  // ---------------------------------------------------------------------------
  // Out-of-range flag
  // ---------------------------------------------------------------------------
`ifdef MEM_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if ((w_rd_acc || w_wr_acc) && w_oor) begin
      r_err <= 1'b1;
    end
  end

  assign mem_err = r_err;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, w_req.addr[1:0], w_wr_last};
`else
  assign mem_err = 1'b0;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, w_req.addr[1:0], w_req.addr[31:AW+2], w_wr_last};
`endif

endmodule : mem_ram

// File: tb/tb_mem_ram.sv
// -----------------------------------------------------------------------------
// tb_mem_ram
// Three mem_ram instances with different depth/latency settings are driven by
// directed scenarios and random transactions. A word-array model with a
// last-read register and sticky error bit supplies every expected value.
//   dut 0 : 256 words, read latency 1, write latency 0
//   dut 1 : 256 words, read latency 3, write latency 2
//   dut 2 :  16 words, read latency 4, write latency 3
// -----------------------------------------------------------------------------
module tb_mem_ram;

  localparam int N_DUT = 3;

  function automatic int unsigned rl(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  function automatic int unsigned wl(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
  endfunction

  function automatic int unsigned dp(input int g);
    return (g == 2) ? 16 : 256;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n_v [N_DUT];
  logic [31:0] addr_v  [N_DUT];
  logic        rstrb_v [N_DUT];
  logic [31:0] wdata_v [N_DUT];
  logic [3:0]  wmask_v [N_DUT];
  logic [31:0] rdata_v [N_DUT];
  logic        rbusy_v [N_DUT];
  logic        wbusy_v [N_DUT];
  logic        err_v   [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mem_ram #(
      .DEPTH_WORDS   (dp(g)),
      .READ_LATENCY  (rl(g)),
      .WRITE_LATENCY (wl(g)),
      .INIT_FILE     ("")
    ) u_dut (
      .clk       (clk),
      .resetn    (rst_n_v[g]),
      .mem_addr  (addr_v[g]),
      .mem_rstrb (rstrb_v[g]),
      .mem_wdata (wdata_v[g]),
      .mem_wmask (wmask_v[g]),
      .mem_rdata (rdata_v[g]),
      .mem_rbusy (rbusy_v[g]),
      .mem_wbusy (wbusy_v[g]),
      .mem_err   (err_v[g])
    );
  end

  // Reference model
  logic [31:0] mdl       [N_DUT][256];
  logic [31:0] exp_rdata [N_DUT];
  bit          exp_err   [N_DUT];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_oor(input int d, input logic [31:0] a);
`ifdef MEM_ERR_EN
    return (a >> 2) >= dp(d);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int idx_of(input int d, input logic [31:0] a);
    return int'((a >> 2) % dp(d));
  endfunction

  // One transaction from the first idle cycle: drives the request, checks
  // busy flags and read data every cycle until the memory is idle again and
  // returns there. With inject set, one junk request is thrown at the memory
  // while it is busy; it must have no effect.
  task automatic op(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [3:0] wmask, input bit inject,
                    output logic [31:0] got);
    int          lr;
    int          lw;
    int          k_end;
    int          ix;
    bit          oor;
    bit          injected;
    bit          rb_exp;
    bit          wb_exp;
    logic [31:0] rd_word;
    lr       = int'(rl(d));
    lw       = int'(wl(d));
    oor      = is_oor(d, addr);
    ix       = idx_of(d, addr);
    injected = 1'b0;
    rd_word  = oor ? 32'hDEADBEEF : mdl[d][ix];
    if (wr && !oor) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mdl[d][ix][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    if (oor && (rd || wr)) exp_err[d] = 1'b1;
    k_end = 1;
    if (rd && lr > k_end) k_end = lr;
    if (wr && lw + 1 > k_end) k_end = lw + 1;

    addr_v[d]  = addr;
    rstrb_v[d] = rd;
    wdata_v[d] = wdata;
    wmask_v[d] = wr ? wmask : 4'h0;
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      rstrb_v[d] = 1'b0;
      wmask_v[d] = 4'h0;
      if (rd && k == lr) exp_rdata[d] = rd_word;
      rb_exp = rd && (k < lr);
      wb_exp = wr && (k <= lw);
      check($sformatf("d%0d.rbusy.k%0d", d, k), 32'(rbusy_v[d]), 32'(rb_exp));
      check($sformatf("d%0d.wbusy.k%0d", d, k), 32'(wbusy_v[d]), 32'(wb_exp));
      check($sformatf("d%0d.rdata.k%0d", d, k), rdata_v[d], exp_rdata[d]);
      if (inject && !injected && (rb_exp || wb_exp)) begin
        injected   = 1'b1;
        addr_v[d]  = $urandom;
        rstrb_v[d] = 1'b1;
        wmask_v[d] = 4'($urandom_range(1, 15));
        wdata_v[d] = $urandom;
      end
    end
    check($sformatf("d%0d.err", d), 32'(err_v[d]), 32'(exp_err[d]));
    got = rdata_v[d];
  endtask

  logic [31:0] got;
  logic [31:0] a;
  bit          rd;
  bit          wr;

  initial begin
    for (int d = 0; d < N_DUT; d++) begin
      rst_n_v[d]   = 1'b0;
      addr_v[d]    = '0;
      rstrb_v[d]   = 1'b0;
      wdata_v[d]   = '0;
      wmask_v[d]   = '0;
      exp_rdata[d] = '0;
      exp_err[d]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      check($sformatf("d%0d.reset.rdata", d), rdata_v[d], 32'h0);
      check($sformatf("d%0d.reset.rbusy", d), 32'(rbusy_v[d]), 32'h0);
      check($sformatf("d%0d.reset.wbusy", d), 32'(wbusy_v[d]), 32'h0);
      check($sformatf("d%0d.reset.err", d), 32'(err_v[d]), 32'h0);
      rst_n_v[d] = 1'b1;
    end

    // Fill every word so later reads never see uninitialised storage.
    for (int d = 0; d < N_DUT; d++) begin
      for (int w = 0; w < int'(dp(d)); w++) begin
        op(d, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0, got);
      end
    end

    // Full-word write then read at L=1, then a single-lane update.
    op(0, 1'b0, 1'b1, 32'd400, 32'h04030201, 4'b1111, 1'b0, got);
    op(0, 1'b1, 1'b0, 32'd400, 32'h0, 4'h0, 1'b0, got);
    check("tp_l1_read", got, 32'h04030201);
    op(0, 1'b0, 1'b1, 32'd400, 32'hAAAAAAAA, 4'b0100, 1'b0, got);
    op(0, 1'b1, 1'b0, 32'd400, 32'h0, 4'h0, 1'b0, got);
    check("tp_lane_read", got, 32'h04AA0201);

    // L=3 read with a strobe thrown in while busy.
    op(1, 1'b0, 1'b1, 32'd400, 32'hCAFEF00D, 4'hF, 1'b0, got);
    op(1, 1'b1, 1'b0, 32'd400, 32'h0, 4'h0, 1'b1, got);
    check("tp_l3_read", got, 32'hCAFEF00D);

    // Same-cycle read and write returns the old word.
    for (int d = 0; d < 2; d++) begin
      op(d, 1'b0, 1'b1, 32'd800, 32'h11111111, 4'hF, 1'b0, got);
      op(d, 1'b1, 1'b1, 32'd800, 32'h22222222, 4'hF, 1'b0, got);
      check($sformatf("d%0d.tp_rbw_old", d), got, 32'h11111111);
      op(d, 1'b1, 1'b0, 32'd800, 32'h0, 4'h0, 1'b0, got);
      check($sformatf("d%0d.tp_rbw_new", d), got, 32'h22222222);
    end

    // Write beyond the array at depth 256.
    op(0, 1'b0, 1'b1, 32'd0, 32'h5A5A5A5A, 4'hF, 1'b0, got);
    op(0, 1'b0, 1'b1, 32'd1024, 32'h12345678, 4'hF, 1'b0, got);
    op(0, 1'b1, 1'b0, 32'd0, 32'h0, 4'h0, 1'b0, got);
`ifdef MEM_ERR_EN
    check("tp_oor_word0", got, 32'h5A5A5A5A);
    check("tp_oor_err", 32'(err_v[0]), 32'h1);
`else
    check("tp_wrap_word0", got, 32'h12345678);
    check("tp_wrap_err", 32'(err_v[0]), 32'h0);
`endif
    op(0, 1'b1, 1'b0, 32'd1024, 32'h0, 4'h0, 1'b0, got);
`ifdef MEM_ERR_EN
    check("tp_oor_read", got, 32'hDEADBEEF);
`else
    check("tp_wrap_read", got, 32'h12345678);
`endif

    // Reset while a read is in flight at L=4; a write coincident with the
    // reset edge must not land.
    op(2, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 1'b0, got);
    addr_v[2]  = 32'h20;
    rstrb_v[2] = 1'b1;
    @(negedge clk);
    rstrb_v[2] = 1'b0;
    @(negedge clk);
    rst_n_v[2] = 1'b0;
    rstrb_v[2] = 1'b1;
    wmask_v[2] = 4'hF;
    wdata_v[2] = 32'h99999999;
    @(negedge clk);
    rst_n_v[2]   = 1'b1;
    rstrb_v[2]   = 1'b0;
    wmask_v[2]   = 4'h0;
    exp_rdata[2] = 32'h0;
    exp_err[2]   = 1'b0;
    check("tp_rst_rdata", rdata_v[2], 32'h0);
    check("tp_rst_rbusy", 32'(rbusy_v[2]), 32'h0);
    check("tp_rst_wbusy", 32'(wbusy_v[2]), 32'h0);
    check("tp_rst_err", 32'(err_v[2]), 32'h0);
    op(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, got);
    check("tp_rst_survive", got, 32'h0BADF00D);

    // Random traffic: reads, writes, combined, with occasional upper address
    // bits and junk requests during busy windows.
    for (int d = 0; d < N_DUT; d++) begin
      for (int n = 0; n < 200; n++) begin
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        if (!rd && !wr) rd = 1'b1;
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = 32'($urandom_range(0, dp(d) * 4 - 1));
        op(d, rd, wr, a, $urandom, 4'($urandom_range(1, 15)),
           ($urandom_range(0, 3) == 0), got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_ram
